// File: rtl/fwperiph_dma_wb_arb.sv
// Two-master to one-slave Wishbone arbiter for the DMA engine (m0) and the register master (m1).
// Round-robin grant held for the whole CYC tenure, with a watchdog that ends stalled strobes with ERR.
module fwperiph_dma_wb_arb #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic [WB_ADDR_WIDTH-1:0]     m0_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]     m0_dat_w_i,
    output logic [WB_DATA_WIDTH-1:0]     m0_dat_r_o,
    input  logic                         m0_cyc_i,
    input  logic                         m0_stb_i,
    input  logic                         m0_we_i,
    input  logic [WB_DATA_WIDTH/8-1:0]   m0_sel_i,
    input  logic [2:0]                   m0_cti_i,
    input  logic [1:0]                   m0_bte_i,
    output logic                         m0_ack_o,
    output logic                         m0_err_o,

    input  logic [WB_ADDR_WIDTH-1:0]     m1_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]     m1_dat_w_i,
    output logic [WB_DATA_WIDTH-1:0]     m1_dat_r_o,
    input  logic                         m1_cyc_i,
    input  logic                         m1_stb_i,
    input  logic                         m1_we_i,
    input  logic [WB_DATA_WIDTH/8-1:0]   m1_sel_i,
    input  logic [2:0]                   m1_cti_i,
    input  logic [1:0]                   m1_bte_i,
    output logic                         m1_ack_o,
    output logic                         m1_err_o,

    output logic [WB_ADDR_WIDTH-1:0]     s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]     s_dat_w_o,
    output logic                         s_we_o,
    output logic [WB_DATA_WIDTH/8-1:0]   s_sel_o,
    output logic [2:0]                   s_cti_o,
    output logic [1:0]                   s_bte_o,
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    input  logic [WB_DATA_WIDTH-1:0]     s_dat_r_i,
    input  logic                         s_ack_i,
    input  logic                         s_err_i,

    output logic [1:0]                   gnt_o,
    output logic                         timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = WD_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state, state_next;
    logic        last_gnt, last_gnt_next;   // 0 = m0 held the bus last, 1 = m1
    logic [15:0] wd_cnt, wd_cnt_next;
    logic        own0, own1, arb_event, stb_raw, wd_fire;

    assign own0  = (state == OWN0);
    assign own1  = (state == OWN1);
    assign gnt_o = {own1, own0};

    // Re-arbitrate only when idle or the owner has released CYC, so tenures are never split.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
        state_next    = state;
        last_gnt_next = last_gnt;
        arb_event     = (state == IDLE) || (own0 && !m0_cyc_i) || (own1 && !m1_cyc_i);
        if (arb_event) begin
            if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
                state_next    = OWN0;
                last_gnt_next = 1'b0;
            end else if (m1_cyc_i) begin
                state_next    = OWN1;
                last_gnt_next = 1'b1;
            end else begin
                state_next    = IDLE;
            end
        end
    end

    always_comb begin
        s_adr_o   = '0;
        s_dat_w_o = '0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_cti_o   = 3'd0;
        s_bte_o   = 2'd0;
        s_cyc_o   = 1'b0;
        stb_raw   = 1'b0;
        if (own0) begin
            s_adr_o   = m0_adr_i;
            s_dat_w_o = m0_dat_w_i;
            s_we_o    = m0_we_i;
            s_sel_o   = m0_sel_i;
            s_cti_o   = m0_cti_i;
            s_bte_o   = m0_bte_i;
            s_cyc_o   = m0_cyc_i;
            stb_raw   = m0_stb_i;
        end else if (own1) begin
            s_adr_o   = m1_adr_i;
            s_dat_w_o = m1_dat_w_i;
            s_we_o    = m1_we_i;
            s_sel_o   = m1_sel_i;
            s_cti_o   = m1_cti_i;
            s_bte_o   = m1_bte_i;
            s_cyc_o   = m1_cyc_i;
            stb_raw   = m1_stb_i;
        end
    end

    // A slave response in the same cycle wins over the watchdog.
    assign wd_fire   = WD_EN && (wd_cnt == WD_LAST) && s_cyc_o && stb_raw && !s_ack_i && !s_err_i;
    assign s_stb_o   = stb_raw && !wd_fire;
    assign timeout_o = wd_fire;

    assign wd_cnt_next = (!stb_raw || s_ack_i || s_err_i || wd_fire) ? 16'd0 : 16'(wd_cnt + 16'd1);

    assign m0_ack_o   = own0 && s_ack_i;
    assign m1_ack_o   = own1 && s_ack_i;
    assign m0_err_o   = own0 && (s_err_i || wd_fire);
    assign m1_err_o   = own1 && (s_err_i || wd_fire);
    assign m0_dat_r_o = s_dat_r_i;
    assign m1_dat_r_o = s_dat_r_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            wd_cnt   <= 16'd0;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
            wd_cnt   <= wd_cnt_next;
        end
    end

endmodule

// File: tb/tb_fwperiph_dma_wb_arb.sv
// Self-checking bench for fwperiph_dma_wb_arb: vector table plus arbitration, watchdog and reset sequences.
// Slave beats are checked against a scoreboard queue filled when each master strobe is driven.
module tb_fwperiph_dma_wb_arb;

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        int          dly;
        logic        serr;
        logic [31:0] rdata;
        logic [1:0]  exp_gnt;
    } vec_t;

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } sb_t;

    logic clk = 1'b0;
    logic rst_i;

    logic [31:0] m_adr[2], m_dat_w[2], m_dat_r[2];
    logic        m_cyc[2], m_stb[2], m_we[2], m_ack[2], m_err[2];
    logic [3:0]  m_sel[2];
    logic [2:0]  m_cti[2];
    logic [1:0]  m_bte[2];

    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic        s_we, s_cyc, s_stb, s_ack, s_err, timeout;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte, gnt;

    logic [31:0] nw_dat_r0, nw_dat_r1, nw_adr, nw_dat_w;
    logic        nw_ack0, nw_ack1, nw_err0, nw_err1, nw_we, nw_cyc, nw_stb, nw_timeout;
    logic [3:0]  nw_sel;
    logic [2:0]  nw_cti;
    logic [1:0]  nw_bte, nw_gnt;

    int  n_checks = 0;
    int  n_fail   = 0;
    sb_t sb[$];

    bit  slave_auto  = 1'b1;
    bit  slave_err   = 1'b0;
    int  slave_delay = 0;

    fwperiph_dma_wb_arb #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(m_adr[0]), .m0_dat_w_i(m_dat_w[0]), .m0_dat_r_o(m_dat_r[0]),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
        .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
        .m1_adr_i(m_adr[1]), .m1_dat_w_i(m_dat_w[1]), .m1_dat_r_o(m_dat_r[1]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
        .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
        .s_adr_o(s_adr), .s_dat_w_o(s_dat_w), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_cti_o(s_cti), .s_bte_o(s_bte), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_dat_r_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(gnt), .timeout_o(timeout)
    );

    // Same stimulus, watchdog disabled.
    fwperiph_dma_wb_arb #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nowd (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(m_adr[0]), .m0_dat_w_i(m_dat_w[0]), .m0_dat_r_o(nw_dat_r0),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
        .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]), .m0_ack_o(nw_ack0), .m0_err_o(nw_err0),
        .m1_adr_i(m_adr[1]), .m1_dat_w_i(m_dat_w[1]), .m1_dat_r_o(nw_dat_r1),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
        .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]), .m1_ack_o(nw_ack1), .m1_err_o(nw_err1),
        .s_adr_o(nw_adr), .s_dat_w_o(nw_dat_w), .s_we_o(nw_we), .s_sel_o(nw_sel),
        .s_cti_o(nw_cti), .s_bte_o(nw_bte), .s_cyc_o(nw_cyc), .s_stb_o(nw_stb),
        .s_dat_r_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(nw_gnt), .timeout_o(nw_timeout)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int m, input logic [31:0] adr, input logic [31:0] dat, input logic we,
                       input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte, input bit push);
        sb_t e;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_adr[m] = adr;
        m_dat_w[m] = dat;
        m_we[m] = we;
        m_sel[m] = sel;
        m_cti[m] = cti;
        m_bte[m] = bte;
        if (push) begin
            e.gnt = (m == 0) ? 2'b01 : 2'b10;
            e.ack = slave_err ? 2'b00 : e.gnt;
            e.err = slave_err ? e.gnt : 2'b00;
            e.adr = adr;
            e.dat = dat;
            e.we  = we;
            e.sel = sel;
            e.cti = cti;
            e.bte = bte;
            sb.push_back(e);
        end
    endtask

    task automatic release_m(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    // Returns the number of falling edges until master m sees ack or err.
    task automatic wait_resp(input int m, input string name, output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (m_ack[m] || m_err[m]) begin
                n = i;
                found = 1'b1;
                break;
            end
        end
        check(name, found, 1'b1);
    endtask

    // Slave model: acknowledges (or errors) after slave_delay wait cycles.
    initial begin : slave_blk
        int w = 0;
        forever begin
            @(posedge clk);
            #2;
            if (slave_auto) begin
                if (s_cyc && s_stb) begin
                    if (w == slave_delay) begin
                        s_ack = !slave_err;
                        s_err = slave_err;
                        w = 0;
                    end else begin
                        s_ack = 1'b0;
                        s_err = 1'b0;
                        w++;
                    end
                end else begin
                    s_ack = 1'b0;
                    s_err = 1'b0;
                    w = 0;
                end
            end
        end
    end

    // Scoreboard: each slave response retires the oldest expected beat.
    initial begin : mon_blk
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst_i && s_cyc && (s_ack || s_err)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got slave response adr 0x%0h, expected none", s_adr);
                end else begin
                    e = sb.pop_front();
                    check("sb_beat",
                          {gnt, m_ack[1], m_ack[0], m_err[1], m_err[0], s_adr, s_dat_w, s_we, s_sel, s_cti, s_bte},
                          {e.gnt, e.ack[1], e.ack[0], e.err[1], e.err[0], e.adr, e.dat, e.we, e.sel, e.cti, e.bte});
                end
            end
        end
    end

    initial begin
        vec_t vecs[5];
        int   n, rise, errat, hits, fires;

        vecs[0] = '{0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00, 2, 1'b0, 32'h0000_0000, 2'b01};
        vecs[1] = '{1, 1'b0, 32'h2000_0040, 32'h0000_0000, 4'h3, 3'b111, 2'b00, 1, 1'b0, 32'hCAFE_F00D, 2'b10};
        vecs[2] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hC, 3'b000, 2'b00, 3, 1'b0, 32'h1234_5678, 2'b01};
        vecs[3] = '{1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'h1, 3'b000, 2'b00, 1, 1'b1, 32'h0000_0000, 2'b10};
        vecs[4] = '{0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 3'b010, 2'b11, 1, 1'b0, 32'h0BAD_F00D, 2'b01};

        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0; m_dat_w[m] = '0; m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
            m_we[m] = 1'b0; m_sel[m] = '0; m_cti[m] = '0; m_bte[m] = '0;
        end
        s_dat_r = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;

        // Reset with m0 requesting: nothing may reach the slave.
        rst_i = 1'b1;
        req(0, 32'h55, 32'h66, 1'b1, 4'hF, 3'b000, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {gnt, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, s_cti, s_bte, m_ack[0], m_ack[1], m_err[0], m_err[1], timeout},
              '0);
        step();
        rst_i = 1'b0;
        release_m(0);
        step();

        // Single-master vectors.
        for (int i = 0; i < 5; i++) begin
            slave_delay = vecs[i].dly;
            slave_err   = vecs[i].serr;
            s_dat_r     = vecs[i].rdata;
            req(vecs[i].m, vecs[i].adr, vecs[i].dat, vecs[i].we, vecs[i].sel, vecs[i].cti, vecs[i].bte, 1'b1);
            @(negedge clk);
            check($sformatf("row%0d_latency_idle", i), {gnt, s_cyc}, 3'b000);
            @(negedge clk);
            check($sformatf("row%0d_grant", i), {gnt, s_cyc}, {vecs[i].exp_gnt, 1'b1});
            wait_resp(vecs[i].m, $sformatf("row%0d_resp_seen", i), n);
            check($sformatf("row%0d_resp_delay", i), n, vecs[i].dly);
            check($sformatf("row%0d_rdata", i), {m_dat_r[0], m_dat_r[1]}, {vecs[i].rdata, vecs[i].rdata});
            step();
            release_m(vecs[i].m);
            @(negedge clk);
            check($sformatf("row%0d_release", i), {gnt, s_cyc, m_ack[vecs[i].m], m_err[vecs[i].m]},
                  {vecs[i].exp_gnt, 3'b000});
            step();
        end
        slave_err = 1'b0;

        // Simultaneous requests from reset: m0 first, one-cycle gap, then round-robin.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        slave_delay = 0;
        req(0, 32'h300, 32'h1111_1111, 1'b1, 4'hF, 3'b000, 2'b00, 1'b1);
        req(1, 32'h400, 32'h2222_2222, 1'b1, 4'hF, 3'b000, 2'b00, 1'b1);
        @(negedge clk);
        check("tie_latency", gnt, 2'b00);
        wait_resp(0, "tie_m0_resp", n);
        check("tie_m0_delay", n, 1);
        step();
        release_m(0);
        @(negedge clk);
        check("tie_gap", {s_cyc, gnt}, 3'b001);
        wait_resp(1, "tie_m1_resp", n);
        check("tie_handover_delay", n, 1);
        step();
        release_m(1);
        step();
        req(0, 32'h304, 32'h3333_3333, 1'b0, 4'hF, 3'b000, 2'b00, 1'b1);
        req(1, 32'h404, 32'h4444_4444, 1'b0, 4'hF, 3'b000, 2'b00, 1'b1);
        wait_resp(0, "rr_m0_resp", n);
        check("rr_m0_delay", n, 2);
        step();
        release_m(0);
        wait_resp(1, "rr_m1_resp", n);
        step();
        release_m(1);
        step();

        // m1 4-beat incrementing burst while m0 holds CYC.
        slave_delay = 1;
        req(1, 32'h200, 32'hB000_0000, 1'b1, 4'hF, 3'b010, 2'b00, 1'b1);
        step();
        m_cyc[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_resp(1, $sformatf("burst_beat%0d", b), n);
            step();
            if (b < 3)
                req(1, 32'h200 + 32'(4 * (b + 1)), 32'hB000_0000 + 32'(b + 1), 1'b1, 4'hF,
                    (b == 2) ? 3'b111 : 3'b010, 2'b00, 1'b1);
            else
                release_m(1);
        end
        @(negedge clk);
        check("burst_drop_gap", {s_cyc, gnt}, 3'b010);
        @(negedge clk);
        check("burst_m0_after", {s_cyc, gnt}, 3'b101);
        step();
        req(0, 32'h500, 32'h5555_5555, 1'b1, 4'hF, 3'b000, 2'b00, 1'b1);
        wait_resp(0, "burst_m0_resp", n);
        step();
        release_m(0);
        step();

        // Watchdog fires on the 8th strobe cycle of a dead slave.
        slave_auto = 1'b0;
        s_ack = 1'b0;
        s_err = 1'b0;
        req(0, 32'h600, 32'h0, 1'b0, 4'hF, 3'b000, 2'b00, 1'b0);
        rise = -1;
        errat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (errat >= 0 && i == errat + 1)
                check("wd_pulse_end", {timeout, m_err[0], s_stb}, 3'b001);
            if (s_stb && rise < 0) rise = i;
            if (m_err[0] && errat < 0) begin
                errat = i;
                check("wd_fire_cycle", {s_stb, timeout, m_err[1], m_ack[0], nw_err0, nw_timeout}, 6'b010000);
            end
        end
        check("wd_fire_delay", errat - rise, 7);
        step();
        release_m(0);
        step();
        step();

        // Long stall: disabled watchdog never fires, enabled one fires every 8 cycles.
        req(0, 32'h610, 32'h0, 1'b0, 4'hF, 3'b000, 2'b00, 1'b0);
        hits = 0;
        fires = 0;
        repeat (1000) begin
            @(negedge clk);
            if (nw_err0 || nw_timeout) hits++;
            if (timeout) fires++;
        end
        check("nowd_no_err", hits, 0);
        check("wd_repeat_count", fires, 124);
        step();
        release_m(0);
        step();
        step();

        // ACK arrives on the watchdog cycle: ack only.
        req(0, 32'h700, 32'h0000_BEEF, 1'b1, 4'hF, 3'b000, 2'b00, 1'b1);
        @(posedge clk);
        repeat (7) @(posedge clk);
        #2;
        s_ack = 1'b1;
        @(negedge clk);
        check("collision_ack_only", {m_ack[0], m_err[0], timeout}, 3'b100);
        step();
        release_m(0);
        s_ack = 1'b0;
        slave_auto = 1'b1;
        step();

        // Reset during m0's second beat, then m1 alone.
        slave_delay = 1;
        req(0, 32'h800, 32'h8888_0000, 1'b1, 4'hF, 3'b010, 2'b00, 1'b1);
        wait_resp(0, "rstmid_beat0", n);
        step();
        req(0, 32'h804, 32'h8888_0001, 1'b1, 4'hF, 3'b111, 2'b00, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_outputs", {gnt, s_cyc, s_stb, m_ack[0], m_ack[1], m_err[0], m_err[1], timeout}, '0);
        step();
        rst_i = 1'b0;
        release_m(0);
        req(1, 32'h900, 32'h9999_9999, 1'b1, 4'hF, 3'b000, 2'b00, 1'b1);
        wait_resp(1, "rstmid_m1_resp", n);
        check("rstmid_m1_delay", n, 3);
        step();
        release_m(1);
        step();
        step();

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
